uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Parametrised UART receive core: the successor to the fixed 8-bit tick-clocked SIPO shift register. It adds the following on top of plain deserialisation:
- input synchronisation, oversampled start-bit detection and mid-bit sampling;
- configurable data width, optional parity and 1 or 2 stop bits;
- a valid/ack output handshake with framing, parity and overrun flags.

It runs on the system clock, with the baud-rate generator's oversample tick as an enable. It sits between the serial pin and the RX FIFO or register interface.

## Interface
- DATA_BITS, 8: data bits per frame, 5..9.
- OVERSAMPLE, 16: ticks per bit period, even, ≥4.
- PARITY_EN, 0: 1 = parity bit expected after the data bits.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  oversample enable, one-clk pulse at OVERSAMPLE × baud.
- rx_in  in  1  asynchronous serial line, idle high.
- data_ack  in  1  consumer accepts data_out; only meaningful while data_valid=1.
- data_out  out  DATA_BITS  received word, LSB = first bit on the line.
- data_valid  out  1  held high from frame completion until the clk in which data_ack=1.
- parity_err  out  1  status of the word in data_out; valid while data_valid=1.
- frame_err  out  1  a stop bit sampled low; valid while data_valid=1.
- overrun  out  1  sticky; set when a frame completes while data_valid=1; cleared only by rst.
- busy  out  1  FSM is not in IDLE.

## Operation
- rx_in passes through a 2-flop synchroniser (reset value 1) to give rx_s. All FSM decisions use rx_s.
- Tick counter cnt has width clog2(OVERSAMPLE). It advances only on tick and is cleared on every state entry.
- **IDLE:** on tick with rx_s=0, go to START with cnt=0.
- **START:** on the tick where cnt reaches OVERSAMPLE/2−1 (mid start bit):
  - rx_s=0: go to DATA with cnt=0, bit index=0.
  - rx_s=1: false start; return to IDLE with no flags and no output.
- **DATA:** on each tick with cnt=OVERSAMPLE−1, sample rx_s:
  - shift it into the MSB of shift register sr (shift right);
  - XOR it into the parity accumulator;
  - after DATA_BITS samples, go to PARITY (if PARITY_EN) or STOP.
- **PARITY:** sample at cnt=OVERSAMPLE−1. Error if (accumulator ^ sample ^ PARITY_ODD) ≠ 0. Then go to STOP.
- **STOP:** sample at cnt=OVERSAMPLE−1, STOP_BITS times. Any low sample sets the frame error. After the last sample, go to IDLE and commit the frame.
- **Commit**, in a single clk:
  - data_out ← sr;
  - parity_err and frame_err ← this frame's results;
  - data_valid ← 1;
  - if data_valid was already 1 and data_ack=0 in that clk: overrun ← 1, and the new frame overwrites data_out and the flags.
- A commit and a data_ack in the same clk: the commit wins, and data_valid stays 1 for the new word.
- A frame error does not suppress the commit; the bad word is delivered with frame_err=1.
- After a frame error with the line held low: IDLE sees rx_s=0 on the next tick and starts a new frame. Break conditions therefore produce repeated frame_err words; no special break handling.
- **Reset values:** state=IDLE, cnt=0, sr=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, synchroniser flops=1.
- rst mid-frame aborts the frame with no commit. Reset has priority over every event in the same clk.

## Timing
- Synchroniser latency: 2 clk from rx_in to rx_s.
- Start detection occurs on the first tick after rx_s falls. Every later sample is a whole number of bit periods (OVERSAMPLE ticks) after the mid-start sample, i.e. at bit centres to within ±1 tick.
- data_valid rises in the clk after the tick that takes the final stop sample. It falls in the clk after data_ack=1 is seen, unless a commit occurs in the same clk.
- A frame spans 1 + DATA_BITS + PARITY_EN + STOP_BITS bit periods. The FSM returns to IDLE at mid last-stop-bit, so back-to-back frames are received with no gap.
- tick may be held high continuously; the block then oversamples at clk rate.

## Test plan
- **Basic frame.** Defaults; send 0x55, 8N1, at OVERSAMPLE=16 → data_out=0x55, data_valid=1, all flags 0. Ack releases data_valid in the next clk.
- **False start.** 0.25-bit low glitch on rx_in → FSM returns to IDLE, data_valid stays 0. A following 0xA3 frame is received correctly.
- **Parity.** PARITY_EN=1, PARITY_ODD=0; send 0x07 with a correct parity bit (1) → parity_err=0. Repeat with parity bit 0 → data_out=0x07, parity_err=1.
- **Framing.** Stop bit driven low on 0x3C → data_out=0x3C, frame_err=1. With STOP_BITS=2 and only the second stop bit low → frame_err=1.
- **Overrun.** Two back-to-back frames 0x11 then 0x22 with no ack → data_out=0x22, overrun=1, data_valid=1. Ack in the same clk as the second commit → data_valid stays 1.
- **Reset mid-frame.** Assert rst after 4 data bits of a frame, then send 0xF0 → no commit from the aborted frame, all outputs 0 during reset, then data_out=0xF0 with no flags set. Also run with DATA_BITS=5: 0x1F → data_out=5'h1F.

Source files
------------

// File: rtl/uart_rx_core_if.sv
// Receive-side word handshake: the core presents a word plus status, the consumer acks it.
// The core drives data/valid/flags; the consumer drives data_ack.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ack;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data_out, data_valid, parity_err, frame_err, overrun,
    input  data_ack
  );

  modport slave (
    input  data_out, data_valid, parity_err, frame_err, overrun,
    output data_ack
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start detection, mid-bit sampling; word valid 1 clk after last stop sample.
// No backpressure on the line: an unacked word is overwritten by the next frame and overrun is flagged.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           rx_in,
  output logic           busy,
  uart_rx_core_if.master rx_if
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic HAS_PAR  = (PARITY_EN != 0);
  localparam logic PAR_ODD  = (PARITY_ODD != 0);
  localparam logic TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                 par_acc_q, par_acc_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 overrun_q, overrun_d;

  logic rx_s, bit_end, mid_start, last_stop, commit;

  assign rx_s      = sync_q[1];
  assign bit_end   = tick && (cnt_q == CNT_LAST);
  assign mid_start = tick && (cnt_q == CNT_MID);
  assign last_stop = !TWO_STOP || stop_idx_q;
  assign commit    = (state_q == S_STOP) && bit_end && last_stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      sr_q       <= '0;
      par_acc_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      sr_q       <= sr_d;
      par_acc_q  <= par_acc_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tick && !rx_s) state_d = S_START;
      S_START:  if (mid_start) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (bit_end && (bit_idx_q == BIT_LAST)) state_d = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end && last_stop) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sync_d     = {sync_q[0], rx_in};
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    sr_d       = sr_q;
    par_acc_d  = par_acc_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = overrun_q;

    // cnt wraps at CNT_LAST so consecutive bits of one state stay a bit period apart
    if (state_d != state_q || state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_START: begin
        if (mid_start && !rx_s) begin
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          par_acc_d  = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          sr_d      = {rx_s, sr_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ rx_s;
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      S_PARITY: if (bit_end) perr_d = par_acc_q ^ rx_s ^ PAR_ODD;
      S_STOP: begin
        if (bit_end) begin
          ferr_d     = ferr_q | !rx_s;
          stop_idx_d = 1'b1;
        end
      end
      default: ;
    endcase

    // a commit beats a same-clk ack so the fresh word is never lost
    if (commit) begin
      data_d     = sr_q;
      valid_d    = 1'b1;
      perr_out_d = perr_q;
      ferr_out_d = ferr_q | !rx_s;
      overrun_d  = overrun_q | (valid_q & !rx_if.data_ack);
    end else if (rx_if.data_ack) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    busy             = (state_q != S_IDLE);
    rx_if.data_out   = data_q;
    rx_if.data_valid = valid_q;
    rx_if.parity_err = perr_out_q;
    rx_if.frame_err  = ferr_out_q;
    rx_if.overrun    = overrun_q;
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: four instances cover 8N1, 8E1, 8N2 and 5N1 framing.
// Tick runs at one pulse every 3 clk, so one bit period is 48 clk.
module tb_uart_rx_core;

  localparam int BIT_CLK = 48;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [3:0] rx_line;
  logic [3:0] ack;
  logic [3:0] busy;
  int         tdiv;
  int         n_checks;
  int         n_fail;

  uart_rx_core_if #(.DATA_BITS(8)) if0 ();
  uart_rx_core_if #(.DATA_BITS(8)) if1 ();
  uart_rx_core_if #(.DATA_BITS(8)) if2 ();
  uart_rx_core_if #(.DATA_BITS(5)) if3 ();

  assign if0.data_ack = ack[0];
  assign if1.data_ack = ack[1];
  assign if2.data_ack = ack[2];
  assign if3.data_ack = ack[3];

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tick(tick), .rx_in(rx_line[0]), .busy(busy[0]), .rx_if(if0));
  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tick(tick), .rx_in(rx_line[1]), .busy(busy[1]), .rx_if(if1));
  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .tick(tick), .rx_in(rx_line[2]), .busy(busy[2]), .rx_if(if2));
  uart_rx_core #(.DATA_BITS(5), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_5n1 (
    .clk(clk), .rst(rst), .tick(tick), .rx_in(rx_line[3]), .busy(busy[3]), .rx_if(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    tdiv = 0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv == 2) ? 0 : tdiv + 1;
      tick = (tdiv == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic send_bit(input int k, input logic b);
    rx_line[k] = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [8:0] data, input int nbits,
                            input bit par_en, input logic par_bit,
                            input logic [1:0] stops, input int nstop);
    send_bit(k, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(k, data[i]);
    if (par_en) send_bit(k, par_bit);
    for (int i = 0; i < nstop; i++) send_bit(k, stops[i]);
    rx_line[k] = 1'b1;
  endtask

  task automatic pulse_ack(input int k);
    ack[k] = 1'b1;
    @(negedge clk);
    ack[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_line = '1;
    ack = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_line = '1;
    ack = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (if0.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", if0.data_out); end
    n_checks++; if (if0.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if0.data_valid); end
    n_checks++; if (if0.parity_err !== 1'b0 || if0.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got p=%b f=%b expected 0 0", if0.parity_err, if0.frame_err); end
    n_checks++; if (if0.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", if0.overrun); end
    n_checks++; if (busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy: got %b expected 0000", busy); end
    n_checks++; if (if3.data_out !== 5'h00 || if3.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_5bit: got %h/%b expected 00/0", if3.data_out, if3.data_valid); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 2'b11, 1);
    n_checks++; if (if0.data_out !== 8'h55) begin n_fail++; $display("FAIL basic_data: got %h expected 55", if0.data_out); end
    n_checks++; if (if0.data_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", if0.data_valid); end
    n_checks++; if ({if0.parity_err, if0.frame_err, if0.overrun} !== 3'b000) begin n_fail++; $display("FAIL basic_flags: got %b expected 000", {if0.parity_err, if0.frame_err, if0.overrun}); end
    pulse_ack(0);
    n_checks++; if (if0.data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_ack_release: got %b expected 0", if0.data_valid); end
  endtask

  task automatic test_false_start();
    do_reset();
    rx_line[0] = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL false_start_detect: busy got %b expected 1", busy[0]); end
    rx_line[0] = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    n_checks++; if (busy[0] !== 1'b0 || if0.data_valid !== 1'b0) begin n_fail++; $display("FAIL false_start_idle: busy/valid got %b/%b expected 0/0", busy[0], if0.data_valid); end
    send_frame(0, 9'h0A3, 8, 1'b0, 1'b0, 2'b11, 1);
    n_checks++; if (if0.data_out !== 8'hA3 || if0.data_valid !== 1'b1) begin n_fail++; $display("FAIL false_start_next: got %h/%b expected a3/1", if0.data_out, if0.data_valid); end
    n_checks++; if (if0.frame_err !== 1'b0) begin n_fail++; $display("FAIL false_start_ferr: got %b expected 0", if0.frame_err); end
  endtask

  task automatic test_parity();
    do_reset();
    send_frame(1, 9'h007, 8, 1'b1, 1'b1, 2'b11, 1);
    n_checks++; if (if1.data_out !== 8'h07 || if1.data_valid !== 1'b1) begin n_fail++; $display("FAIL parity_good_data: got %h/%b expected 07/1", if1.data_out, if1.data_valid); end
    n_checks++; if (if1.parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_good_err: got %b expected 0", if1.parity_err); end
    pulse_ack(1);
    send_frame(1, 9'h007, 8, 1'b1, 1'b0, 2'b11, 1);
    n_checks++; if (if1.data_out !== 8'h07) begin n_fail++; $display("FAIL parity_bad_data: got %h expected 07", if1.data_out); end
    n_checks++; if (if1.parity_err !== 1'b1 || if1.frame_err !== 1'b0) begin n_fail++; $display("FAIL parity_bad_err: got p=%b f=%b expected 1 0", if1.parity_err, if1.frame_err); end
  endtask

  task automatic test_framing();
    do_reset();
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 2'b00, 1);
    n_checks++; if (if0.data_out !== 8'h3C || if0.data_valid !== 1'b1) begin n_fail++; $display("FAIL frame_data: got %h/%b expected 3c/1", if0.data_out, if0.data_valid); end
    n_checks++; if (if0.frame_err !== 1'b1 || if0.parity_err !== 1'b0) begin n_fail++; $display("FAIL frame_err: got f=%b p=%b expected 1 0", if0.frame_err, if0.parity_err); end
    do_reset();
    send_frame(2, 9'h081, 8, 1'b0, 1'b0, 2'b11, 2);
    n_checks++; if (if2.data_out !== 8'h81 || if2.frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_2stop_good: got %h f=%b expected 81 0", if2.data_out, if2.frame_err); end
    pulse_ack(2);
    send_frame(2, 9'h03C, 8, 1'b0, 1'b0, 2'b01, 2);
    n_checks++; if (if2.data_out !== 8'h3C || if2.frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_2stop_bad: got %h f=%b expected 3c 1", if2.data_out, if2.frame_err); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1);
    n_checks++; if (if0.data_out !== 8'h22 || if0.data_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_data: got %h/%b expected 22/1", if0.data_out, if0.data_valid); end
    n_checks++; if (if0.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b expected 1", if0.overrun); end

    // Frames are 480 clk apart and tick-aligned, so the second commit lands 480 clk after the first.
    do_reset();
    fork
      begin
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1);
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1);
      end
      begin
        int w = 0;
        while (if0.data_valid !== 1'b1 && w < 2000) begin
          @(negedge clk);
          w++;
        end
        n_checks++;
        if (w >= 2000) begin
          n_fail++; $display("FAIL overrun_ack_wait: data_valid got %b expected 1 within 2000 clk", if0.data_valid);
        end else begin
          repeat (479) @(negedge clk);
          n_checks++; if (if0.data_out !== 8'h11 || if0.data_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_ack_pre: got %h/%b expected 11/1", if0.data_out, if0.data_valid); end
          pulse_ack(0);
          n_checks++; if (if0.data_out !== 8'h22 || if0.data_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_ack_same_clk: got %h/%b expected 22/1", if0.data_out, if0.data_valid); end
          n_checks++; if (if0.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_ack_flag: got %b expected 0", if0.overrun); end
        end
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 2'b11, 1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    rst = 1'b1;
    rx_line[0] = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (if0.data_out !== 8'h00 || if0.data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got %h/%b expected 00/0", if0.data_out, if0.data_valid); end
    n_checks++; if ({if0.parity_err, if0.frame_err, if0.overrun, busy[0]} !== 4'b0000) begin n_fail++; $display("FAIL midrst_flags: got %b expected 0000", {if0.parity_err, if0.frame_err, if0.overrun, busy[0]}); end
    rst = 1'b0;
    repeat (2 * BIT_CLK) @(negedge clk);
    n_checks++; if (if0.data_valid !== 1'b0 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_no_commit: valid/busy got %b/%b expected 0/0", if0.data_valid, busy[0]); end
    send_frame(0, 9'h0F0, 8, 1'b0, 1'b0, 2'b11, 1);
    n_checks++; if (if0.data_out !== 8'hF0 || if0.data_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_data: got %h/%b expected f0/1", if0.data_out, if0.data_valid); end
    n_checks++; if ({if0.parity_err, if0.frame_err, if0.overrun} !== 3'b000) begin n_fail++; $display("FAIL midrst_clean: got %b expected 000", {if0.parity_err, if0.frame_err, if0.overrun}); end
  endtask

  task automatic test_five_bit();
    do_reset();
    send_frame(3, 9'h01F, 5, 1'b0, 1'b0, 2'b11, 1);
    n_checks++; if (if3.data_out !== 5'h1F || if3.data_valid !== 1'b1) begin n_fail++; $display("FAIL five_bit_1f: got %h/%b expected 1f/1", if3.data_out, if3.data_valid); end
    pulse_ack(3);
    send_frame(3, 9'h00A, 5, 1'b0, 1'b0, 2'b11, 1);
    n_checks++; if (if3.data_out !== 5'h0A || if3.frame_err !== 1'b0 || if3.overrun !== 1'b0) begin n_fail++; $display("FAIL five_bit_0a: got %h f=%b o=%b expected 0a 0 0", if3.data_out, if3.frame_err, if3.overrun); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    rx_line = '1;
    ack = '0;
    test_reset();
    test_basic();
    test_false_start();
    test_parity();
    test_framing();
    test_overrun();
    test_reset_mid_frame();
    test_five_bit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
